instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Writer-side counterpart to the instruction memory: receives a program as a byte stream and writes it into the memory's write port as 32-bit words.
- Assembles bytes little-endian into words and issues one write per word at consecutive word addresses.
- Holds the CPU (`cpu_hold`) for the whole load, so the core only fetches once the image is complete.
- Sits between a host byte source (UART/JTAG bridge) and the instruction memory write port.

Parameters:
- `MEM_WORDS`, 1024: instruction memory depth in words; upper bound on a legal word count.
- `BASE_ADDR`, 0: byte address of the first word written; must be a multiple of 4.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- `in_valid`  in  1  source has a byte on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  write strobe to instruction memory.
- `mem_addr`  out  32  byte address of the write; the memory indexes by address>>2.
- `mem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  stall request to the core.
- `done`  out  1  load completed successfully.
- `error`  out  1  header word count exceeded `MEM_WORDS`.

Behaviour:
- **Clock and reset:** one clock domain. `rst_n` low asynchronously forces IDLE and clears every output to 0 (`mem_addr` 0, `mem_wdata` 0), plus the word counter, byte counter and length register.
- **Reset mid-load:** memory contents already written stay in memory; the loader does not wipe them.
- **Handshake:** a byte transfers only on a `clk` edge with `in_valid` and `in_ready` both 1.
  - `in_ready` = 1 only in LEN and DATA, and is combinational from state.
  - `in_valid` may stay high; stalls on the source side are legal at any time.
- **Stream format:**
  - 2-byte little-endian word count N (first byte = N[7:0]).
  - Followed by 4·N data bytes; first byte of each word goes to bits [7:0], the fourth to bits [31:24].
- **States:**
  - **IDLE:** outputs idle, `cpu_hold` = 0. `start` → LEN, with `cpu_hold` = 1 from the next cycle.
  - **LEN:** accept 2 bytes.
    - After the 2nd byte: N = 0 → DONE; N > `MEM_WORDS` → ERR; else → DATA with word index = 0.
  - **DATA:** accept bytes into a shift/assembly register. The 4th byte → WRITE.
  - **WRITE:** exactly one cycle.
    - `mem_we` = 1, `mem_addr` = `BASE_ADDR` + 4·index, `mem_wdata` = assembled word, `in_ready` = 0.
    - Index increments; if new index == N → DONE, else → DATA.
  - **DONE:** `done` = 1, `cpu_hold` = 0. `start` → LEN and clears `done`.
  - **ERR:** `error` = 1, `cpu_hold` stays 1, `in_ready` = 0. `start` → LEN and clears `error`; reset also exits.
- **Latency:** 1 cycle from the 4th accepted byte to `mem_we`. Minimum 5 cycles per word when `in_valid` is held high.
- **Busy:** `start` is ignored in LEN, DATA and WRITE.
- **Widths:**
  - Index and N use 16 bits.
  - `mem_addr` is computed in 32 bits; index·4 never exceeds (`MEM_WORDS`−1)·4 + `BASE_ADDR`.
  - N == `MEM_WORDS` is legal; N == `MEM_WORDS`+1 is an error.
- **Outputs outside WRITE:** `mem_we` = 0; `mem_addr` and `mem_wdata` hold their last values.

Test Plan:
- **Reset:** assert `rst_n` = 0 mid-DATA → all outputs 0 at once. Release, with no `start` → `in_ready` = 0 and `cpu_hold` = 0 indefinitely.
- **Single word:** `start`, then bytes 01 00 14 00 A0 E3 → one `mem_we` pulse with `mem_addr` = 0, `mem_wdata` = 0xE3A00014. Then `done` = 1 and `cpu_hold` = 0 on the next cycle.
- **Three words with stalls:** `start`, then N = 3 with `in_valid` gaps of 0–3 cycles → writes at `mem_addr` 0, 4, 8 in order with correct words. `cpu_hold` stays 1 until the cycle after the third write.
- **Boundaries:**
  - N = 0 → DONE right after the header, with no `mem_we`.
  - N = 1025 (bytes 01 04) → `error` = 1, `in_ready` = 0, `cpu_hold` = 1.
  - A later `start` clears `error`.
  - N = 1024 is accepted.
- **Ignored start:** pulse `start` during DATA → no state change; the word still completes correctly.
- **Back-to-back loads:** with `BASE_ADDR` = 0x100, a second `start` after DONE → `done` drops, and the first write of the new load goes to `mem_addr` 0x100.

Source files
------------

// File: rtl/instruction_loader.sv
// instruction_loader: receives a length-prefixed byte stream and writes it to instruction memory as little-endian words
module instruction_loader #(
    parameter int MEM_WORDS = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;

    localparam logic [31:0] BASE = 32'(BASE_ADDR);
    localparam logic [31:0] MAXW = 32'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        take;
    logic [15:0] n_hdr;
    logic [31:0] next_word;

    assign in_ready  = (state_q == S_LEN) || (state_q == S_DATA);
    assign mem_we    = (state_q == S_WRITE);
    assign cpu_hold  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE) || (state_q == S_ERR);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Next-state: header capture, byte assembly and the one-cycle write per word
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        idx_d      = idx_q;
        word_d     = word_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        take       = in_valid && in_ready;
        n_hdr      = {in_data, len_q[7:0]};
        next_word  = {in_data, word_q[31:8]};
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = 2'd0;
                end
            end
            S_LEN: begin
                if (take) begin
                    if (byte_cnt_q == 2'd0) begin
                        len_d      = {8'h00, in_data};
                        byte_cnt_d = 2'd1;
                    end else begin
                        len_d      = n_hdr;
                        byte_cnt_d = 2'd0;
                        idx_d      = 16'd0;
                        state_d    = (n_hdr == 16'd0) ? S_DONE :
                                     ({16'h0000, n_hdr} > MAXW) ? S_ERR : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    word_d     = next_word;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wdata_d = next_word;
                        addr_d  = BASE + {14'b0, idx_q, 2'b00};
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + 16'd1;
                state_d = (idx_q + 16'd1 == len_q) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset leaves memory contents alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            len_q      <= 16'd0;
            idx_q      <= 16'd0;
            word_q     <= 32'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: randomized loads against a stream-level model with a queue scoreboard on the write port
module tb_instruction_loader;
    localparam int          MW   = 1024;
    localparam logic [31:0] BASE = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_we, cpu_hold, done, error;
    logic [31:0] mem_addr, mem_wdata;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    instruction_loader #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("write_addr", mem_addr, e[63:32]);
                    chk("write_data", mem_wdata, e[31:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_hold", {31'd0, cpu_hold}, 32'd1);
        chk("start_clears_flags", {30'd0, done, error}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Model: N from the header, then word i = bytes 4i..4i+3 little-endian at BASE+4i
    task automatic load(input int n, input int maxgap, input bit mid_start, input bit fixed, input logic [31:0] w0);
        logic [7:0] bytes[$];
        logic [31:0] w;
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        if (n <= MW) begin
            for (int i = 0; i < n; i++) begin
                w = (fixed && i == 0) ? w0 : $urandom;
                exp_q.push_back({BASE + 32'(4 * i), w});
                for (int k = 0; k < 4; k++) bytes.push_back(8'(w >> (8 * k)));
            end
        end
        pulse_start();
        for (int i = 0; i < bytes.size(); i++) begin
            if (mid_start && i == 4) start = 1'b1;
            send_byte(bytes[i], (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
            start = 1'b0;
            if (i == 1 && n == 0) begin
                chk("n0_done", {31'd0, done}, 32'd1);
                chk("n0_hold", {31'd0, cpu_hold}, 32'd0);
            end
            if (i == 1 && n > MW) begin
                chk("err_flag", {31'd0, error}, 32'd1);
                chk("err_ready", {31'd0, in_ready}, 32'd0);
                chk("err_hold", {31'd0, cpu_hold}, 32'd1);
                repeat (3) @(negedge clk);
                chk("err_sticky", {29'd0, error, in_ready, cpu_hold}, 32'b101);
            end
        end
        if (n > 0 && n <= MW) begin
            chk("last_we", {31'd0, mem_we}, 32'd1);
            chk("hold_in_write", {31'd0, cpu_hold}, 32'd1);
            @(negedge clk);
            chk("final_done", {31'd0, done}, 32'd1);
            chk("final_hold", {31'd0, cpu_hold}, 32'd0);
            chk("all_written", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outs", {mem_addr, mem_wdata} == 64'd0 ? 32'd0 : 32'd1, 32'd0);
        chk("rst_flags", {26'd0, mem_we, in_ready, cpu_hold, done, error, 1'b0}, 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_quiet", {30'd0, in_ready, cpu_hold}, 32'd0);
        end
        load(1, 0, 1'b0, 1'b1, 32'hE3A00014);
        for (int r = 0; r < 4; r++) load($urandom_range(1, 6), 3, 1'b0, 1'b0, 32'h0);
        load(3, 3, 1'b1, 1'b0, 32'h0);
        load(0, 2, 1'b0, 1'b0, 32'h0);
        load(MW + 1, 1, 1'b0, 1'b0, 32'h0);
        load(2, 1, 1'b0, 1'b0, 32'h0);
        load(MW, 0, 1'b0, 1'b0, 32'h0);
        // Reset in the middle of a word
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_addr", mem_addr, 32'd0);
        chk("midrst_data", mem_wdata, 32'd0);
        chk("midrst_flags", {27'd0, mem_we, in_ready, cpu_hold, done, error}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {30'd0, in_ready, cpu_hold}, 32'd0);
        load(2, 0, 1'b0, 1'b0, 32'h0);
        load(1, 0, 1'b0, 1'b0, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
